// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, per-sprite state record and scheduler states
package sprite_pkg;

  localparam int COORD_W      = 12;
  localparam int SPRITE_IDX_W = 3;

  typedef struct packed {
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               dir_x;
    logic               dir_y;
  } sprite_state_t;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sprite_step.sv
// rtl/sprite_step.sv - one-axis step/bounce: move one pixel, then pick next direction from the old position
module sprite_step
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  input  logic [COORD_W-1:0] max_pos,
  input  logic [COORD_W-1:0] min_pos,
  output logic [COORD_W-1:0] pos_next,
  output logic               dir_next
);

  always_comb begin
    pos_next = dir ? (pos + 12'd1) : (pos - 12'd1);
    dir_next = dir;
    if (pos > max_pos) begin
      dir_next = 1'b0;
    end else if (pos < min_pos) begin
      dir_next = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - frame-synchronous sprite register file, shared step datapath and overlay hit test
// Optional overlap detector compiled in with SPRITE_COLLISION_EN.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int MAX_X     = 500,
  parameter int MAX_Y     = 493,
  parameter int MIN_POS   = 10,
  parameter int BOX_SIZE  = 32,
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [11:0] cfg_x,
  input  logic [11:0] cfg_y,
  input  logic [1:0]  cfg_dir,
  output logic        cfg_ready,
  output logic        busy,
  output logic        update_done,
  output logic        hit,
  output logic [2:0]  hit_id
`ifdef SPRITE_COLLISION_EN
  ,
  output logic        collision
`endif
);

  localparam logic [SPRITE_IDX_W-1:0] LAST_IDX = SPRITE_IDX_W'(N_SPRITES - 1);
  localparam logic [SPRITE_IDX_W:0]   N_LIMIT  = (SPRITE_IDX_W + 1)'(N_SPRITES);
  localparam logic [7:0]              DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [COORD_W:0]        BOX_W    = (COORD_W + 1)'(BOX_SIZE);
  localparam logic [COORD_W-1:0]      MAX_X_C  = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0]      MAX_Y_C  = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0]      MIN_C    = COORD_W'(MIN_POS);

  sched_state_t             state_q, state_d;
  logic [SPRITE_IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]               frame_cnt_q, frame_cnt_d;
  sprite_state_t            sprites_q [N_SPRITES];
  sprite_state_t            sprites_d [N_SPRITES];
  logic                     hit_q, hit_d;
  logic [SPRITE_IDX_W-1:0]  hit_id_q, hit_id_d;

  sprite_state_t            cur;
  logic [COORD_W-1:0]       nx, ny;
  logic                     ndx, ndy;
  logic                     cfg_accept;
  logic [N_SPRITES-1:0]     hit_vec;

  function automatic sprite_state_t reset_sprite(int i);
    sprite_state_t s;
    s.pos_x = COORD_W'(MIN_POS + 2 * BOX_SIZE * i);
    s.pos_y = COORD_W'(MIN_POS);
    s.dir_x = 1'b1;
    s.dir_y = 1'b1;
    return s;
  endfunction

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx_q == SPRITE_IDX_W'(i)) cur = sprites_q[i];
    end
  end

  sprite_step u_step_x (
    .pos      (cur.pos_x),
    .dir      (cur.dir_x),
    .max_pos  (MAX_X_C),
    .min_pos  (MIN_C),
    .pos_next (nx),
    .dir_next (ndx)
  );

  sprite_step u_step_y (
    .pos      (cur.pos_y),
    .dir      (cur.dir_y),
    .max_pos  (MAX_Y_C),
    .min_pos  (MIN_C),
    .pos_next (ny),
    .dir_next (ndy)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    sprites_d   = sprites_q;
    cfg_ready   = (state_q == IDLE);
    busy        = (state_q == UPDATE);
    update_done = 1'b0;
    cfg_accept  = cfg_we && cfg_ready && ({1'b0, cfg_idx} < N_LIMIT);
    case (state_q)
      IDLE: begin
        // A write coinciding with frame_start lands first, so UPDATE steps the new values.
        if (cfg_accept) begin
          for (int i = 0; i < N_SPRITES; i++) begin
            if (cfg_idx == SPRITE_IDX_W'(i)) begin
              sprites_d[i] = '{pos_x: cfg_x, pos_y: cfg_y, dir_x: cfg_dir[0], dir_y: cfg_dir[1]};
            end
          end
        end
        if (frame_start) begin
          if (frame_cnt_q == DIV_LAST) begin
            frame_cnt_d = '0;
            idx_d       = '0;
            state_d     = UPDATE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      UPDATE: begin
        for (int i = 0; i < N_SPRITES; i++) begin
          if (idx_q == SPRITE_IDX_W'(i)) begin
            sprites_d[i] = '{pos_x: nx, pos_y: ny, dir_x: ndx, dir_y: ndy};
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = IDLE;
          update_done = !rst;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_vec  = '0;
    hit_d    = 1'b0;
    hit_id_d = '0;
    // 13-bit compares keep pos+BOX_SIZE from wrapping near the top of the coordinate range.
    for (int i = 0; i < N_SPRITES; i++) begin
      hit_vec[i] = ({1'b0, x} > {1'b0, sprites_q[i].pos_x}) &&
                   ({1'b0, x} < ({1'b0, sprites_q[i].pos_x} + BOX_W)) &&
                   ({1'b0, y} > {1'b0, sprites_q[i].pos_y}) &&
                   ({1'b0, y} < ({1'b0, sprites_q[i].pos_y} + BOX_W));
    end
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_d    = 1'b1;
        hit_id_d = SPRITE_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      hit_q       <= 1'b0;
      hit_id_q    <= '0;
      for (int i = 0; i < N_SPRITES; i++) sprites_q[i] <= reset_sprite(i);
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      hit_q       <= hit_d;
      hit_id_q    <= hit_id_d;
      sprites_q   <= sprites_d;
    end
  end

  assign hit    = hit_q;
  assign hit_id = hit_id_q;

`ifdef SPRITE_COLLISION_EN
  logic collision_q, collision_d;
  logic overlap;

  // Clearing x&(x-1) leaves a nonzero result exactly when two or more sprites hit.
  always_comb begin
    overlap     = (hit_vec & (hit_vec - {{(N_SPRITES-1){1'b0}}, 1'b1})) != '0;
    collision_d = overlap | (collision_q & ~update_done);
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - self-checking bench for sprite_scheduler (default and FRAME_DIV=3 instances)
module tb_sprite_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [11:0] x = '0, y = '0;
  logic        fs = 1'b0, we = 1'b0;
  logic [2:0]  cidx = '0;
  logic [11:0] cx = '0, cy = '0;
  logic [1:0]  cdir = '0;
  logic        fs3 = 1'b0, we3 = 1'b0;
  logic [2:0]  cidx3 = '0;
  logic [11:0] cx3 = '0, cy3 = '0;
  logic [1:0]  cdir3 = '0;

  logic        cfg_ready, busy, update_done, hit;
  logic [2:0]  hit_id;
  logic        cfg_ready3, busy3, update_done3, hit3;
  logic [2:0]  hit_id3;
`ifdef SPRITE_COLLISION_EN
  logic        collision, collision3;
  logic        coll_at_done;
`endif

  sprite_scheduler dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(fs),
    .cfg_we(we), .cfg_idx(cidx), .cfg_x(cx), .cfg_y(cy), .cfg_dir(cdir),
    .cfg_ready(cfg_ready), .busy(busy), .update_done(update_done),
    .hit(hit), .hit_id(hit_id)
`ifdef SPRITE_COLLISION_EN
    , .collision(collision)
`endif
  );

  sprite_scheduler #(.FRAME_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(fs3),
    .cfg_we(we3), .cfg_idx(cidx3), .cfg_x(cx3), .cfg_y(cy3), .cfg_dir(cdir3),
    .cfg_ready(cfg_ready3), .busy(busy3), .update_done(update_done3),
    .hit(hit3), .hit_id(hit_id3)
`ifdef SPRITE_COLLISION_EN
    , .collision(collision3)
`endif
  );

  int mx[4], my[4];
  bit mdx[4], mdy[4];
  int mcnt[2];
  int div[2] = '{1, 3};
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 10 + 64 * i; my[i] = 10; mdx[i] = 1'b1; mdy[i] = 1'b1;
    end
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic bounce(inout int p, inout bit d, input int lim);
    int np;
    bit nd;
    np = d ? (p + 1) % 4096 : (p + 4095) % 4096;
    nd = (p > lim) ? 1'b0 : (p < 10) ? 1'b1 : d;
    p = np; d = nd;
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      bounce(mx[i], mdx[i], 500);
      bounce(my[i], mdy[i], 493);
    end
  endtask

  task automatic check_pos(string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_x%0d", tag, i), {20'd0, dut.sprites_q[i].pos_x}, mx[i]);
      chk($sformatf("%s_y%0d", tag, i), {20'd0, dut.sprites_q[i].pos_y}, my[i]);
      chk($sformatf("%s_dx%0d", tag, i), {31'd0, dut.sprites_q[i].dir_x}, {31'd0, mdx[i]});
      chk($sformatf("%s_dy%0d", tag, i), {31'd0, dut.sprites_q[i].dir_y}, {31'd0, mdy[i]});
    end
  endtask

  task automatic check_pixel(string tag, int px, int py);
    bit eh;
    int eid;
    eh = 1'b0; eid = 0;
    x = 12'(px); y = 12'(py);
    tick();
    for (int i = 3; i >= 0; i--) begin
      if (px > mx[i] && px < mx[i] + 32 && py > my[i] && py < my[i] + 32) begin
        eh = 1'b1; eid = i;
      end
    end
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({tag, "_id"}, {29'd0, hit_id}, eid);
  endtask

  task automatic do_cfg(int which, int i, int px, int py, int d);
    int k;
    bit rdy;
    if (which == 0) begin
      we = 1'b1; cidx = 3'(i); cx = 12'(px); cy = 12'(py); cdir = 2'(d);
    end else begin
      we3 = 1'b1; cidx3 = 3'(i); cx3 = 12'(px); cy3 = 12'(py); cdir3 = 2'(d);
    end
    for (k = 0; k < 50; k++) begin
      rdy = (which == 0) ? cfg_ready : cfg_ready3;
      tick();
      if (rdy) break;
    end
    we = 1'b0; we3 = 1'b0;
    chk("cfg_wait", {31'd0, k < 50}, 32'd1);
    if (which == 0 && i < 4) begin
      mx[i] = px; my[i] = py; mdx[i] = d[0]; mdy[i] = d[1];
    end
  endtask

  task automatic run_frame(string tag, int which);
    int bc, dc, dat;
    bit upd;
    bc = 0; dc = 0; dat = -1;
    upd = (mcnt[which] == div[which] - 1);
    mcnt[which] = upd ? 0 : mcnt[which] + 1;
    if (which == 0) fs = 1'b1; else fs3 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      fs = 1'b0; fs3 = 1'b0;
      if ((which == 0) ? busy : busy3) bc++;
      if ((which == 0) ? update_done : update_done3) begin
        dc++; dat = k;
`ifdef SPRITE_COLLISION_EN
        coll_at_done = collision;
`endif
      end
    end
    chk({tag, "_busy_cycles"}, bc, upd ? 4 : 0);
    chk({tag, "_done_count"}, dc, upd ? 1 : 0);
    chk({tag, "_done_at"}, dat, upd ? 4 : -1);
    chk({tag, "_ready_after"}, {31'd0, (which == 0) ? cfg_ready : cfg_ready3}, 32'd1);
    if (upd && which == 0) model_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_hit", {31'd0, hit}, 0);
    chk("rst_hit_id", {29'd0, hit_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, update_done}, 0);
    chk("rst_ready", {31'd0, cfg_ready}, 1);
    chk("rst_ready3", {31'd0, cfg_ready3}, 1);
    chk("rst_hit3", {31'd0, hit3}, 0);
`ifdef SPRITE_COLLISION_EN
    chk("rst_coll", {31'd0, collision}, 0);
    chk("rst_coll3", {31'd0, collision3}, 0);
`endif
    check_pos("rst");

    run_frame("t1", 0);
    chk("t1_s0x", {20'd0, dut.sprites_q[0].pos_x}, 11);
    chk("t1_s0y", {20'd0, dut.sprites_q[0].pos_y}, 11);
    chk("t1_s1x", {20'd0, dut.sprites_q[1].pos_x}, 75);
    check_pos("t1");

    do_cfg(0, 2, 501, 100, 3);
    run_frame("t2a", 0);
    chk("t2_x_a", {20'd0, dut.sprites_q[2].pos_x}, 502);
    chk("t2_dx_a", {31'd0, dut.sprites_q[2].dir_x}, 0);
    run_frame("t2b", 0);
    chk("t2_x_b", {20'd0, dut.sprites_q[2].pos_x}, 501);

    do_cfg(0, 0, 9, 50, 2);
    run_frame("t3a", 0);
    chk("t3_x_a", {20'd0, dut.sprites_q[0].pos_x}, 8);
    chk("t3_dx_a", {31'd0, dut.sprites_q[0].dir_x}, 1);
    run_frame("t3b", 0);
    chk("t3_x_b", {20'd0, dut.sprites_q[0].pos_x}, 9);
    check_pos("t3");

    do_cfg(0, 0, 100, 100, 0);
    do_cfg(0, 1, 100, 100, 0);
    check_pixel("t4_in", 110, 110);
    chk("t4_in_const", {31'd0, hit}, 1);
    chk("t4_in_id_const", {29'd0, hit_id}, 0);
`ifdef SPRITE_COLLISION_EN
    chk("t6_coll_set", {31'd0, collision}, 1);
`endif
    check_pixel("t4_left_edge", 100, 110);
    chk("t4_left_const", {31'd0, hit}, 0);
    check_pixel("t4_right_in", 131, 110);
    chk("t4_right_in_const", {31'd0, hit}, 1);
    check_pixel("t4_right_edge", 132, 110);
    chk("t4_right_const", {31'd0, hit}, 0);
`ifdef SPRITE_COLLISION_EN
    check_pixel("t6_away", 0, 0);
    chk("t6_coll_sticky", {31'd0, collision}, 1);
    coll_at_done = 1'b0;
    run_frame("t6", 0);
    chk("t6_coll_at_done", {31'd0, coll_at_done}, 1);
    chk("t6_coll_cleared", {31'd0, collision}, 0);
`endif

    we = 1'b1; cidx = 3'd1; cx = 12'd300; cy = 12'd300; cdir = 2'b00; fs = 1'b1;
    tick();
    we = 1'b0; fs = 1'b0;
    mx[1] = 300; my[1] = 300; mdx[1] = 1'b0; mdy[1] = 1'b0;
    repeat (6) tick();
    model_step();
    chk("simul_s1x", {20'd0, dut.sprites_q[1].pos_x}, 299);
    check_pos("simul");

    for (int it = 0; it < 30; it++) begin
      case ($urandom % 3)
        0: do_cfg(0, int'($urandom % 8), int'($urandom_range(5, 505)),
                  int'($urandom_range(5, 500)), int'($urandom % 4));
        1: begin
          run_frame($sformatf("rnd%0d", it), 0);
          check_pos($sformatf("rnd%0d", it));
        end
        default: begin
          int s;
          s = int'($urandom % 4);
          check_pixel($sformatf("rndpix%0d", it), mx[s] + int'($urandom_range(0, 40)) - 2,
                      my[s] + int'($urandom_range(0, 40)) - 2);
        end
      endcase
    end
    check_pos("rnd_end");

    run_frame("t5a", 1);
    run_frame("t5b", 1);
    fs3 = 1'b1;
    tick();
    fs3 = 1'b0;
    chk("t5_busy_on_third", {31'd0, busy3}, 1);
    tick();
    fs3 = 1'b1;
    tick();
    fs3 = 1'b0;
    chk("t5_ready_low", {31'd0, cfg_ready3}, 0);
    do_cfg(1, 0, 200, 50, 3);
    chk("t5_cfg_x", {20'd0, dut3.sprites_q[0].pos_x}, 200);
    chk("t5_cfg_y", {20'd0, dut3.sprites_q[0].pos_y}, 50);
    mcnt[1] = 0;
    run_frame("t5c", 1);
    run_frame("t5d", 1);
    run_frame("t5e", 1);

    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_done", {31'd0, update_done}, 0);
    rst = 1'b0;
    dc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (update_done) dc++;
    end
    chk("rstmid_no_done", dc, 0);
    chk("rstmid_ready", {31'd0, cfg_ready}, 1);
`ifdef SPRITE_COLLISION_EN
    chk("rstmid_coll", {31'd0, collision}, 0);
`endif
    model_reset();
    check_pos("rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
